// File: rtl/unified_mem_arbiter_pkg.sv
// Shared types for the unified IF/MEM memory arbiter.
// FSM encodings and the byte-lane width of the word address.
package unified_mem_arbiter_pkg;

  typedef enum logic [2:0] {
    ARB_IDLE   = 3'd0,
    ARB_D_WAIT = 3'd1,
    ARB_D_RESP = 3'd2,
    ARB_I_WAIT = 3'd3,
    ARB_I_RESP = 3'd4
  } arb_state_e;

  localparam int unsigned WORD_LSB = 2;

endpackage

// File: rtl/unified_mem_arbiter_if.sv
// Datapath-side and RAM-side signals of the unified memory arbiter.
// slave is the arbiter view; master is the pipeline/RAM view.
interface unified_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              inst_ren;
  logic [ADDR_W-1:0] inst_addr;
  logic [DATA_W-1:0] inst_data;
  logic              inst_ready;
  logic              mem_ren;
  logic              mem_wen;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;
  logic              stall_req;
  logic              ram_req;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic              ram_ack;

  modport slave (
    input  inst_ren, inst_addr,
    input  mem_ren, mem_wen, mem_addr, mem_wdata,
    input  ram_rdata, ram_ack,
    output inst_data, inst_ready,
    output mem_rdata, mem_ready, stall_req,
    output ram_req, ram_we, ram_addr, ram_wdata
  );

  modport master (
    output inst_ren, inst_addr,
    output mem_ren, mem_wen, mem_addr, mem_wdata,
    output ram_rdata, ram_ack,
    input  inst_data, inst_ready,
    input  mem_rdata, mem_ready, stall_req,
    input  ram_req, ram_we, ram_addr, ram_wdata
  );

endinterface

// File: rtl/unified_mem_arbiter_inst_line_buffer.sv
// One-entry instruction line buffer: fill, invalidate-on-match,
// and a combinational hit/data lookup.
module unified_mem_arbiter_inst_line_buffer #(
  parameter int TAG_W  = 30,
  parameter int DATA_W = 32,
  parameter bit EN     = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fill_en,
  input  logic [TAG_W-1:0]  fill_tag,
  input  logic [DATA_W-1:0] fill_data,
  input  logic              inv_en,
  input  logic [TAG_W-1:0]  inv_tag,
  input  logic              lookup_en,
  input  logic [TAG_W-1:0]  lookup_tag,
  output logic              hit,
  output logic [DATA_W-1:0] hit_data
);

  logic              valid_q;
  logic [TAG_W-1:0]  tag_q;
  logic [DATA_W-1:0] data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      data_q  <= '0;
    end else if (fill_en) begin
      valid_q <= 1'b1;
      tag_q   <= fill_tag;
      data_q  <= fill_data;
    end else if (inv_en && (tag_q == inv_tag)) begin
      valid_q <= 1'b0;
    end
  end

  assign hit = EN && valid_q && lookup_en
            && (tag_q == lookup_tag);
  assign hit_data = hit ? data_q : '0;

endmodule

// File: rtl/unified_mem_arbiter.sv
// Arbitrates one single-port RAM between IF fetch and MEM load/store,
// with data priority, a fetch line buffer and pipeline stall request.
module unified_mem_arbiter
  import unified_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter bit BUF_EN = 1'b1
) (
  input logic                  clk,
  input logic                  rst_n,
  unified_mem_arbiter_if.slave bus
);

  localparam int TAG_W = ADDR_W - WORD_LSB;

  arb_state_e state_q, state_d;

  logic              ram_req_q, ram_req_d;
  logic              ram_we_q, ram_we_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
  logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;

  logic              mem_req;
  logic              mem_ready;
  logic              hit;
  logic [DATA_W-1:0] hit_data;
  logic              fill_en;
  logic              inv_en;
  logic              unused_lsb;

  assign mem_req = bus.mem_ren | bus.mem_wen;

  always_comb begin
    state_d     = state_q;
    ram_req_d   = ram_req_q;
    ram_we_d    = ram_we_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    mem_rdata_d = mem_rdata_q;
    fill_en     = 1'b0;
    inv_en      = 1'b0;
    unique case (state_q)
      ARB_IDLE: begin
        if (mem_req) begin
          ram_req_d   = 1'b1;
          ram_we_d    = bus.mem_wen;
          ram_addr_d  = {bus.mem_addr[ADDR_W-1:WORD_LSB],
                         {WORD_LSB{1'b0}}};
          ram_wdata_d = bus.mem_wdata;
          state_d     = ARB_D_WAIT;
        end else if (bus.inst_ren && !hit) begin
          ram_req_d  = 1'b1;
          ram_we_d   = 1'b0;
          ram_addr_d = {bus.inst_addr[ADDR_W-1:WORD_LSB],
                        {WORD_LSB{1'b0}}};
          state_d    = ARB_I_WAIT;
        end
      end
      ARB_D_WAIT: begin
        if (bus.ram_ack) begin
          ram_req_d = 1'b0;
          ram_we_d  = 1'b0;
          inv_en    = ram_we_q;
          if (!ram_we_q) mem_rdata_d = bus.ram_rdata;
          state_d   = ARB_D_RESP;
        end
      end
      ARB_I_WAIT: begin
        if (bus.ram_ack) begin
          ram_req_d = 1'b0;
          ram_we_d  = 1'b0;
          fill_en   = 1'b1;
          state_d   = ARB_I_RESP;
        end
      end
      // RESP states never issue, so a held request is not replayed
      ARB_D_RESP: state_d = ARB_IDLE;
      ARB_I_RESP: state_d = ARB_IDLE;
      default:    state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ARB_IDLE;
      ram_req_q   <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      mem_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      ram_req_q   <= ram_req_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      mem_rdata_q <= mem_rdata_d;
    end
  end

  unified_mem_arbiter_inst_line_buffer #(
    .TAG_W  (TAG_W),
    .DATA_W (DATA_W),
    .EN     (BUF_EN)
  ) u_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .fill_en    (fill_en),
    .fill_tag   (ram_addr_q[ADDR_W-1:WORD_LSB]),
    .fill_data  (bus.ram_rdata),
    .inv_en     (inv_en),
    .inv_tag    (ram_addr_q[ADDR_W-1:WORD_LSB]),
    .lookup_en  (bus.inst_ren),
    .lookup_tag (bus.inst_addr[ADDR_W-1:WORD_LSB]),
    .hit        (hit),
    .hit_data   (hit_data)
  );

  assign mem_ready = (state_q == ARB_D_RESP);

  assign bus.mem_ready  = mem_ready;
  assign bus.mem_rdata  = mem_rdata_q;
  assign bus.inst_ready = hit;
  assign bus.inst_data  = hit_data;
  assign bus.ram_req    = ram_req_q;
  assign bus.ram_we     = ram_we_q;
  assign bus.ram_addr   = ram_addr_q;
  assign bus.ram_wdata  = ram_wdata_q;

  // Gated by reset so a held request cannot freeze a resetting pipe
  assign bus.stall_req = rst_n
    & ((mem_req & ~mem_ready) | (bus.inst_ren & ~hit));

  assign unused_lsb = ^{bus.inst_addr[WORD_LSB-1:0],
                        bus.mem_addr[WORD_LSB-1:0]};

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Bench for unified_mem_arbiter: variable-latency RAM responder,
// transaction-level reference model, directed and random scenarios.
module tb_unified_mem_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  unified_mem_arbiter_if bus ();

  unified_mem_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  bit ram_auto = 1'b0;
  int ram_lat  = 1;
  logic [31:0] ram_mem [logic [31:0]];
  logic [31:0] exp_mem [logic [31:0]];

  bit          m_valid = 1'b0;
  logic [31:0] m_tag   = '0;
  logic [31:0] m_data  = '0;
  logic [31:0] m_rdata = '0;

  int          e_d_at, e_i_at;
  logic [31:0] e_d_data, e_i_data;
  logic [64:0] e_issues [$];

  int          o_d_at, o_i_at;
  logic [31:0] o_d_data, o_i_data;
  logic [64:0] o_issues [$];
  bit          stall_log [0:63];

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0F0F_1234;
  endfunction

  function automatic logic [31:0] ram_rd(input logic [31:0] a);
    return ram_mem.exists(a) ? ram_mem[a] : init_word(a);
  endfunction

  function automatic logic [31:0] exp_rd(input logic [31:0] a);
    return exp_mem.exists(a) ? exp_mem[a] : init_word(a);
  endfunction

  // RAM: acks on the lat-th cycle that ram_req is seen high
  initial begin
    int cnt;
    cnt = 0;
    forever begin
      @(negedge clk);
      if (ram_auto) begin
        bus.ram_ack = 1'b0;
        bus.ram_rdata = $urandom;
        if (!rst_n || !bus.ram_req) begin
          cnt = 0;
        end else begin
          cnt++;
          if (cnt >= ram_lat) begin
            bus.ram_ack = 1'b1;
            cnt = 0;
            if (bus.ram_we)
              ram_mem[bus.ram_addr] = bus.ram_wdata;
            else
              bus.ram_rdata = ram_rd(bus.ram_addr);
          end
        end
      end
    end
  end

  // Transaction-level prediction; sample 0 is the cycle the request appears
  task automatic model_txn(
    input bit d_en, input bit d_we,
    input logic [31:0] d_addr, input logic [31:0] d_wd,
    input bit i_en, input logic [31:0] i_addr, input int lat
  );
    logic [31:0] dw, iw;
    bit hit;
    int base;
    dw = d_addr & ~32'h3;
    iw = i_addr & ~32'h3;
    e_issues.delete();
    e_d_at = -1;
    e_i_at = -1;
    e_i_data = '0;
    hit = i_en && m_valid && (m_tag == iw);
    if (i_en && hit) begin
      e_i_at = 0;
      e_i_data = m_data;
    end
    if (d_en) begin
      e_issues.push_back({d_we, dw, d_we ? d_wd : 32'h0});
      e_d_at = lat + 1;
      if (d_we) begin
        exp_mem[dw] = d_wd;
        if (m_valid && m_tag == dw) m_valid = 1'b0;
      end else begin
        m_rdata = exp_rd(dw);
      end
    end
    e_d_data = m_rdata;
    if (i_en && !hit) begin
      base = d_en ? lat + 2 : 0;
      e_issues.push_back({1'b0, iw, 32'h0});
      e_i_at = base + lat + 1;
      m_valid = 1'b1;
      m_tag = iw;
      m_data = exp_rd(iw);
      e_i_data = m_data;
    end
  endtask

  task automatic run_txn(
    input bit d_en, input bit d_we,
    input logic [31:0] d_addr, input logic [31:0] d_wd,
    input bit i_en, input logic [31:0] i_addr,
    input int lat, input int ncyc
  );
    logic prev_req;
    ram_lat = lat;
    o_issues.delete();
    o_d_at = -1;
    o_i_at = -1;
    o_d_data = '0;
    o_i_data = '0;
    @(negedge clk);
    bus.mem_ren   = d_en & ~d_we;
    bus.mem_wen   = d_en & d_we;
    bus.mem_addr  = d_addr;
    bus.mem_wdata = d_wd;
    bus.inst_ren  = i_en;
    bus.inst_addr = i_addr;
    prev_req = bus.ram_req;
    for (int s = 0; s < ncyc; s++) begin
      if (s > 0) begin
        @(negedge clk);
        if (o_d_at >= 0) begin
          bus.mem_ren = 1'b0;
          bus.mem_wen = 1'b0;
        end
        if (o_i_at >= 0) bus.inst_ren = 1'b0;
      end
      #1;
      stall_log[s] = bus.stall_req;
      if (bus.ram_req && !prev_req)
        o_issues.push_back({bus.ram_we, bus.ram_addr,
                            bus.ram_we ? bus.ram_wdata : 32'h0});
      prev_req = bus.ram_req;
      if (d_en && o_d_at < 0 && bus.mem_ready) begin
        o_d_at = s;
        o_d_data = bus.mem_rdata;
      end
      if (i_en && o_i_at < 0 && bus.inst_ready) begin
        o_i_at = s;
        o_i_data = bus.inst_data;
      end
    end
    bus.mem_ren  = 1'b0;
    bus.mem_wen  = 1'b0;
    bus.inst_ren = 1'b0;
  endtask

  function automatic int ncyc_of();
    return ((e_d_at > e_i_at) ? e_d_at : e_i_at) + 3;
  endfunction

  function automatic int stall_bad(
    input bit d_en, input bit i_en, input int n
  );
    int bad;
    bit exp;
    bad = 0;
    for (int s = 0; s < n; s++) begin
      exp = (d_en && s < e_d_at) || (i_en && s < e_i_at);
      if (stall_log[s] != exp) bad++;
    end
    return bad;
  endfunction

  function automatic bit issues_ok();
    if (o_issues.size() != e_issues.size()) return 1'b0;
    foreach (e_issues[k])
      if (o_issues[k] !== e_issues[k]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic test_reset();
    logic [170:0] outs;
    ram_auto = 1'b0;
    rst_n = 1'b0;
    bus.ram_ack   = 1'b1;
    bus.ram_rdata = 32'hFFFF_FFFF;
    bus.mem_ren   = 1'b1;
    bus.mem_wen   = 1'b0;
    bus.mem_addr  = 32'h0000_0104;
    bus.mem_wdata = 32'h1234_5678;
    bus.inst_ren  = 1'b1;
    bus.inst_addr = 32'h0000_0040;
    repeat (3) @(negedge clk);
    #1;
    outs = {bus.ram_req, bus.ram_we, bus.ram_addr,
            bus.ram_wdata, bus.mem_rdata, bus.mem_ready,
            bus.inst_ready, bus.inst_data, 32'h0, 3'h0};
    checks++;
    if (outs !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h want 0", outs);
    end
    checks++;
    if (bus.stall_req !== 1'b0) begin
      errors++;
      $display("FAIL reset_stall: got %b want 0", bus.stall_req);
    end
    @(negedge clk);
    bus.mem_ren  = 1'b0;
    bus.inst_ren = 1'b0;
    bus.ram_ack  = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({bus.ram_req, bus.mem_ready, bus.stall_req} !== 3'b000) begin
      errors++;
      $display("FAIL reset_release: req/rdy/stall=%b want 000",
               {bus.ram_req, bus.mem_ready, bus.stall_req});
    end
    ram_auto = 1'b1;
  endtask

  task automatic test_fetch_miss_hit();
    exp_mem[32'h40] = 32'h2408_0005;
    ram_mem[32'h40] = 32'h2408_0005;
    model_txn(0, 0, 0, 0, 1, 32'h40, 2);
    run_txn(0, 0, 0, 0, 1, 32'h40, 2, ncyc_of());
    checks++;
    if (o_i_at !== 3 || o_i_data !== 32'h2408_0005) begin
      errors++;
      $display("FAIL fetch_miss: at=%0d data=%h want at=3 data=24080005",
               o_i_at, o_i_data);
    end
    checks++;
    if (!issues_ok()) begin
      errors++;
      $display("FAIL fetch_miss_issue: got %0d reqs want %0d",
               o_issues.size(), e_issues.size());
    end
    model_txn(0, 0, 0, 0, 1, 32'h40, 2);
    run_txn(0, 0, 0, 0, 1, 32'h40, 2, ncyc_of());
    checks++;
    if (o_i_at !== 0 || o_i_data !== e_i_data || o_issues.size() != 0) begin
      errors++;
      $display("FAIL fetch_hit: at=%0d data=%h reqs=%0d want 0 %h 0",
               o_i_at, o_i_data, o_issues.size(), e_i_data);
    end
  endtask

  task automatic test_contention();
    int n;
    model_txn(1, 0, 32'h100, 32'h0, 1, 32'h44, 2);
    n = ncyc_of();
    run_txn(1, 0, 32'h100, 32'h0, 1, 32'h44, 2, n);
    checks++;
    if (!issues_ok()) begin
      errors++;
      $display("FAIL contention_order: got %0d reqs first %h want %0d first %h",
               o_issues.size(), o_issues.size() ? o_issues[0] : 65'h0,
               e_issues.size(), e_issues[0]);
    end
    checks++;
    if (o_d_at !== 3 || o_i_at !== 7) begin
      errors++;
      $display("FAIL contention_lat: d=%0d i=%0d want d=3 i=7",
               o_d_at, o_i_at);
    end
    checks++;
    if (o_d_data !== e_d_data || o_i_data !== e_i_data) begin
      errors++;
      $display("FAIL contention_data: d=%h i=%h want d=%h i=%h",
               o_d_data, o_i_data, e_d_data, e_i_data);
    end
    checks++;
    if (stall_bad(1, 1, n) != 0) begin
      errors++;
      $display("FAIL contention_stall: bad cycles=%0d want 0",
               stall_bad(1, 1, n));
    end
  endtask

  task automatic test_store_invalidate();
    model_txn(0, 0, 0, 0, 1, 32'h40, 1);
    run_txn(0, 0, 0, 0, 1, 32'h40, 1, ncyc_of());
    model_txn(1, 1, 32'h42, 32'hDEAD_BEEF, 0, 0, 3);
    run_txn(1, 1, 32'h42, 32'hDEAD_BEEF, 0, 0, 3, ncyc_of());
    checks++;
    if (o_issues.size() != 1 ||
        o_issues[0] !== {1'b1, 32'h40, 32'hDEAD_BEEF}) begin
      errors++;
      $display("FAIL store_issue: got %0d reqs first %h want 1 %h",
               o_issues.size(), o_issues.size() ? o_issues[0] : 65'h0,
               {1'b1, 32'h40, 32'hDEAD_BEEF});
    end
    checks++;
    if (o_d_at !== e_d_at) begin
      errors++;
      $display("FAIL store_ready: at=%0d want %0d", o_d_at, e_d_at);
    end
    model_txn(0, 0, 0, 0, 1, 32'h40, 2);
    run_txn(0, 0, 0, 0, 1, 32'h40, 2, ncyc_of());
    checks++;
    if (o_i_at !== 3 || o_i_data !== 32'hDEAD_BEEF || !issues_ok()) begin
      errors++;
      $display("FAIL store_refetch: at=%0d data=%h reqs=%0d want 3 deadbeef 1",
               o_i_at, o_i_data, o_issues.size());
    end
  endtask

  task automatic test_zero_wait();
    model_txn(1, 0, 32'h61, 32'h0, 0, 0, 1);
    run_txn(1, 0, 32'h61, 32'h0, 0, 0, 1, ncyc_of() + 2);
    checks++;
    if (o_d_at !== 2 || o_d_data !== e_d_data) begin
      errors++;
      $display("FAIL zero_wait: at=%0d data=%h want 2 %h",
               o_d_at, o_d_data, e_d_data);
    end
    checks++;
    if (o_issues.size() != 1) begin
      errors++;
      $display("FAIL zero_wait_dup: reqs=%0d want 1", o_issues.size());
    end
  endtask

  task automatic test_random();
    bit d_en, d_we, i_en;
    logic [31:0] da, ia, wd;
    int op, lat, n;
    for (int it = 0; it < 40; it++) begin
      op  = $urandom_range(0, 4);
      lat = $urandom_range(1, 4);
      d_en = (op != 2);
      d_we = (op == 1) || (op == 4);
      i_en = (op >= 2);
      da = 32'h40 + 4 * $urandom_range(0, 7) + $urandom_range(0, 3);
      ia = 32'h40 + 4 * $urandom_range(0, 7) + $urandom_range(0, 3);
      wd = $urandom;
      model_txn(d_en, d_we, da, wd, i_en, ia, lat);
      n = ncyc_of();
      run_txn(d_en, d_we, da, wd, i_en, ia, lat, n);
      checks++;
      if (o_d_at !== e_d_at || o_i_at !== e_i_at) begin
        errors++;
        $display("FAIL rand_lat[%0d]: d=%0d i=%0d want d=%0d i=%0d",
                 it, o_d_at, o_i_at, e_d_at, e_i_at);
      end
      checks++;
      if (d_en && o_d_data !== e_d_data) begin
        errors++;
        $display("FAIL rand_rdata[%0d]: got %h want %h",
                 it, o_d_data, e_d_data);
      end
      checks++;
      if (i_en && o_i_data !== e_i_data) begin
        errors++;
        $display("FAIL rand_idata[%0d]: got %h want %h",
                 it, o_i_data, e_i_data);
      end
      checks++;
      if (!issues_ok()) begin
        errors++;
        $display("FAIL rand_issue[%0d]: reqs=%0d want %0d",
                 it, o_issues.size(), e_issues.size());
      end
      checks++;
      if (stall_bad(d_en, i_en, n) != 0) begin
        errors++;
        $display("FAIL rand_stall[%0d]: bad cycles=%0d want 0",
                 it, stall_bad(d_en, i_en, n));
      end
    end
  endtask

  task automatic test_reset_mid();
    int n_rdy, n_req;
    ram_lat = 8;
    @(negedge clk);
    bus.mem_ren  = 1'b1;
    bus.mem_addr = 32'h80;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (bus.ram_req !== 1'b1) begin
      errors++;
      $display("FAIL rmid_inflight: ram_req=%b want 1", bus.ram_req);
    end
    ram_auto = 1'b0;
    bus.ram_ack = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.ram_req, bus.stall_req} !== 2'b00) begin
      errors++;
      $display("FAIL rmid_async: req/stall=%b want 00",
               {bus.ram_req, bus.stall_req});
    end
    @(negedge clk);
    bus.mem_ren = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    bus.ram_ack   = 1'b1;
    bus.ram_rdata = 32'hBAD0_BAD0;
    @(negedge clk);
    bus.ram_ack = 1'b0;
    n_rdy = 0;
    n_req = 0;
    repeat (4) begin
      #1;
      if (bus.mem_ready) n_rdy++;
      if (bus.ram_req) n_req++;
      @(negedge clk);
    end
    checks++;
    if (n_rdy != 0 || n_req != 0 || bus.mem_rdata !== 32'h0) begin
      errors++;
      $display("FAIL rmid_late_ack: rdy=%0d req=%0d rdata=%h want 0 0 0",
               n_rdy, n_req, bus.mem_rdata);
    end
    ram_auto = 1'b1;
    m_valid = 1'b0;
    m_rdata = '0;
    model_txn(0, 0, 0, 0, 1, 32'h40, 2);
    run_txn(0, 0, 0, 0, 1, 32'h40, 2, ncyc_of());
    checks++;
    if (o_i_at !== e_i_at || o_i_data !== e_i_data) begin
      errors++;
      $display("FAIL rmid_recover: at=%0d data=%h want %0d %h",
               o_i_at, o_i_data, e_i_at, e_i_data);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.inst_ren  = 1'b0;
    bus.inst_addr = '0;
    bus.mem_ren   = 1'b0;
    bus.mem_wen   = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.ram_ack   = 1'b0;
    bus.ram_rdata = '0;
    test_reset();
    test_fetch_miss_hit();
    test_contention();
    test_store_invalidate();
    test_zero_wait();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
